// File: rtl/issue_exe_lanes.sv
// issue_exe_lanes: N-lane issue-to-EXE pipeline register.
// Steers the (single) special instruction of each issued portion onto
// SPEC_LANE, tags every lane with its original slot index, and splits
// groups holding several specials over multiple cycles via a hold buffer.
module issue_exe_lanes #(
    parameter int LANES     = 2,
    parameter int PAY_W     = 160,
    parameter int SPEC_LANE = LANES - 1,
    parameter int AGE_W     = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES-1:0]       in_special,
    input  logic [LANES-1:0]       in_div,
    input  logic [LANES*32-1:0]    in_pc,
    input  logic [LANES*32-1:0]    in_pc_pre,
    input  logic [LANES*PAY_W-1:0] in_pay,
    output logic                   in_ready,
    input  logic                   stall,
    input  logic                   flush,
    output logic [LANES-1:0]       ex_valid,
    output logic [LANES*AGE_W-1:0] ex_age,
    output logic [LANES*32-1:0]    ex_pc,
    output logic [LANES*32-1:0]    ex_pc_pre,
    output logic [LANES-1:0]       ex_br_pd,
    output logic [LANES*PAY_W-1:0] ex_pay,
    output logic                   ex_div_en
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;

    // hold buffer: remaining mask plus a copy of the split group
    logic [LANES-1:0]       rem_r;
    logic [LANES-1:0]       hold_spec_r;
    logic [LANES-1:0]       hold_div_r;
    logic [LANES*32-1:0]    hold_pc_r;
    logic [LANES*32-1:0]    hold_pc_pre_r;
    logic [LANES*PAY_W-1:0] hold_pay_r;

    logic                   drain_s;
    logic [LANES-1:0]       src_valid_s;
    logic [LANES-1:0]       src_spec_s;
    logic [LANES-1:0]       src_div_s;
    logic [31:0]            src_pc_a     [LANES];
    logic [31:0]            src_pc_pre_a [LANES];
    logic [PAY_W-1:0]       src_pay_a    [LANES];

    logic [LANES-1:0]       issue_s;
    logic [LANES-1:0]       remain_s;
    logic                   has_spec_s;
    logic                   issue_stop_s;

    logic [LANES-1:0]       lane_use_s;
    logic [AGE_W-1:0]       lane_src_s [LANES];
    int                     fill_s;
    int                     tgt_s;

    logic [LANES-1:0]       ex_valid_nxt_s;
    logic [LANES*AGE_W-1:0] ex_age_nxt_s;
    logic [LANES*32-1:0]    ex_pc_nxt_s;
    logic [LANES*32-1:0]    ex_pc_pre_nxt_s;
    logic [LANES-1:0]       ex_br_pd_nxt_s;
    logic [LANES*PAY_W-1:0] ex_pay_nxt_s;
    logic                   ex_div_en_nxt_s;

    logic [LANES-1:0]       ex_valid_r;
    logic [LANES*AGE_W-1:0] ex_age_r;
    logic [LANES*32-1:0]    ex_pc_r;
    logic [LANES*32-1:0]    ex_pc_pre_r;
    logic [LANES-1:0]       ex_br_pd_r;
    logic [LANES*PAY_W-1:0] ex_pay_r;
    logic                   ex_div_en_r;

    assign drain_s     = (state_r == ST_DRAIN);
    assign src_valid_s = drain_s ? rem_r       : in_valid;
    assign src_spec_s  = drain_s ? hold_spec_r : in_special;
    assign src_div_s   = drain_s ? hold_div_r  : in_div;
    assign in_ready    = ~rst & ~stall & ~flush & (state_r == ST_IDLE);

    // source slot fields: live inputs when idle, held copy while draining
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (drain_s) begin
                src_pc_a[i]     = hold_pc_r[i*32 +: 32];
                src_pc_pre_a[i] = hold_pc_pre_r[i*32 +: 32];
                src_pay_a[i]    = hold_pay_r[i*PAY_W +: PAY_W];
            end else begin
                src_pc_a[i]     = in_pc[i*32 +: 32];
                src_pc_pre_a[i] = in_pc_pre[i*32 +: 32];
                src_pay_a[i]    = in_pay[i*PAY_W +: PAY_W];
            end
        end
    end

    // issue set: oldest-first prefix of the source set, cut before the second special
    always_comb begin
        issue_s      = '0;
        has_spec_s   = 1'b0;
        issue_stop_s = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (src_valid_s[i] && !issue_stop_s) begin
                if (src_spec_s[i] && has_spec_s) begin
                    issue_stop_s = 1'b1;
                end else begin
                    issue_s[i] = 1'b1;
                    if (src_spec_s[i]) begin
                        has_spec_s = 1'b1;
                    end else begin
                        has_spec_s = has_spec_s;
                    end
                end
            end else begin
                issue_stop_s = issue_stop_s;
            end
        end
        remain_s = src_valid_s & ~issue_s;
    end

    // lane steering: special to SPEC_LANE, others pack the remaining lanes in age order
    always_comb begin
        lane_use_s = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_src_s[l] = '0;
        end
        fill_s = (SPEC_LANE == 0) ? 1 : 0;
        tgt_s  = 0;
        for (int i = 0; i < LANES; i++) begin
            if (issue_s[i]) begin
                if (!has_spec_s) begin
                    tgt_s = i;
                end else if (src_spec_s[i]) begin
                    tgt_s = SPEC_LANE;
                end else begin
                    tgt_s  = fill_s;
                    fill_s = fill_s + 1;
                    if (fill_s == SPEC_LANE) begin
                        fill_s = fill_s + 1;
                    end else begin
                        fill_s = fill_s;
                    end
                end
                for (int l = 0; l < LANES; l++) begin
                    if (l == tgt_s) begin
                        lane_use_s[l] = 1'b1;
                        lane_src_s[l] = AGE_W'(i);
                    end else begin
                        lane_use_s[l] = lane_use_s[l];
                    end
                end
            end else begin
                tgt_s = tgt_s;
            end
        end
    end

    // next lane contents; unused lanes are driven to all-zero
    always_comb begin
        ex_valid_nxt_s  = lane_use_s;
        ex_age_nxt_s    = '0;
        ex_pc_nxt_s     = '0;
        ex_pc_pre_nxt_s = '0;
        ex_br_pd_nxt_s  = '0;
        ex_pay_nxt_s    = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_use_s[l]) begin
                ex_age_nxt_s[l*AGE_W +: AGE_W] = lane_src_s[l];
                ex_pc_nxt_s[l*32 +: 32]        = src_pc_a[lane_src_s[l]];
                ex_pc_pre_nxt_s[l*32 +: 32]    = src_pc_pre_a[lane_src_s[l]];
                ex_br_pd_nxt_s[l]              = (src_pc_pre_a[lane_src_s[l]] !=
                                                  (src_pc_a[lane_src_s[l]] + 32'd4));
                ex_pay_nxt_s[l*PAY_W +: PAY_W] = src_pay_a[lane_src_s[l]];
            end else begin
                ex_br_pd_nxt_s[l] = 1'b0;
            end
        end
        ex_div_en_nxt_s = lane_use_s[SPEC_LANE] & src_div_s[lane_src_s[SPEC_LANE]];
    end

    // next state: flush forces IDLE, stall freezes, otherwise split/drain tracking
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else if (stall) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = (|remain_s) ? ST_DRAIN : ST_IDLE;
                ST_DRAIN: state_nxt_s = (|remain_s) ? ST_DRAIN : ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // EXE lane registers and hold buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r    <= '0;
            ex_age_r      <= '0;
            ex_pc_r       <= '0;
            ex_pc_pre_r   <= '0;
            ex_br_pd_r    <= '0;
            ex_pay_r      <= '0;
            ex_div_en_r   <= 1'b0;
            rem_r         <= '0;
            hold_spec_r   <= '0;
            hold_div_r    <= '0;
            hold_pc_r     <= '0;
            hold_pc_pre_r <= '0;
            hold_pay_r    <= '0;
        end else if (flush) begin
            ex_valid_r  <= '0;
            ex_age_r    <= '0;
            ex_pc_r     <= '0;
            ex_pc_pre_r <= '0;
            ex_br_pd_r  <= '0;
            ex_pay_r    <= '0;
            ex_div_en_r <= 1'b0;
            rem_r       <= '0;
        end else if (!stall) begin
            ex_valid_r  <= ex_valid_nxt_s;
            ex_age_r    <= ex_age_nxt_s;
            ex_pc_r     <= ex_pc_nxt_s;
            ex_pc_pre_r <= ex_pc_pre_nxt_s;
            ex_br_pd_r  <= ex_br_pd_nxt_s;
            ex_pay_r    <= ex_pay_nxt_s;
            ex_div_en_r <= ex_div_en_nxt_s;
            rem_r       <= remain_s;
            // capture the whole group only when an idle accept has to be split
            if (!drain_s && (|remain_s)) begin
                hold_spec_r   <= in_special;
                hold_div_r    <= in_div;
                hold_pc_r     <= in_pc;
                hold_pc_pre_r <= in_pc_pre;
                hold_pay_r    <= in_pay;
            end
        end
    end

    assign ex_valid  = ex_valid_r;
    assign ex_age    = ex_age_r;
    assign ex_pc     = ex_pc_r;
    assign ex_pc_pre = ex_pc_pre_r;
    assign ex_br_pd  = ex_br_pd_r;
    assign ex_pay    = ex_pay_r;
    assign ex_div_en = ex_div_en_r;

endmodule

// File: doc/issue_exe_lanes.md
# issue_exe_lanes

Parametrised N-lane issue-to-EXE pipeline register. It is the successor to the fixed dual-issue stage. It steers instructions that need the special unit (mul/div/mem) onto a dedicated lane and tags every lane with its program-order age. When a group holds more than one special instruction, it splits the group over several cycles using an internal hold buffer and a ready/valid handshake. It sits between the issue buffer/regfile read and the EXE stage.

## Interface
Parameters:
- LANES, 2: issue width; legal values 2..4.
- PAY_W, 160: per-lane opaque payload width (operands, imm, alu_op, sels, rf/mem controls).
- SPEC_LANE, LANES-1: index of the lane wired to the special unit.
- AGE_W, $clog2(LANES): width of the age tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  LANES  per-slot valid; contiguous from slot 0 (slot 0 is oldest)
- in_special  in  LANES  slot needs the special unit
- in_div  in  LANES  slot is a divide (subset of special)
- in_pc  in  LANES*32  slot PC
- in_pc_pre  in  LANES*32  slot predicted next PC
- in_pay  in  LANES*PAY_W  slot payload
- in_ready  out  1  group accepted this cycle when in_ready & |in_valid
- stall  in  1  EXE stall (DCache | div)
- flush  in  1  branch flush
- ex_valid  out  LANES  lane valid
- ex_age  out  LANES*AGE_W  original slot index of the lane contents
- ex_pc, ex_pc_pre  out  LANES*32  lane PC / predicted PC
- ex_br_pd  out  LANES  1 iff pc_pre != pc+4
- ex_pay  out  LANES*PAY_W  lane payload
- ex_div_en  out  1  SPEC_LANE holds a valid divide

## Operation
- States: IDLE (no held work) and DRAIN (hold buffer holds a remaining mask and a copy of the group's pc/pc_pre/pay/special/div).
- Source set each cycle:
  - IDLE: input slots with in_valid.
  - DRAIN: held slots whose remaining-mask bit is 1.
- Issue set: the longest age-ordered prefix of the source set that contains at most one special.
- Steering:
  - The special in the issue set goes to SPEC_LANE.
  - Non-special members fill the other lanes in ascending age, in ascending lane index.
  - A group with zero specials maps identity (slot i to lane i).
  - Unused lanes: ex_valid=0, and ex_pay, ex_pc, ex_pc_pre, ex_age, ex_br_pd forced to 0.
- Capacity rule: if the issue set has no special and SPEC_LANE would be needed for non-specials, non-specials may occupy SPEC_LANE. The issue set is therefore never limited by lane count, only by the second special.
- Transitions:
  - IDLE to DRAIN: on accept, when the source set is larger than the issue set. The remainder is loaded into the hold buffer.
  - DRAIN stays in DRAIN while the remainder stays non-empty after issuing.
  - DRAIN to IDLE: when the last held slot issues.
- in_ready = ~rst & ~stall & ~flush & (state==IDLE).
- ex_div_en = ex_valid[SPEC_LANE] & held/input div bit of that instruction.
- ex_br_pd uses 32-bit wraparound for pc+4.

## Timing
- Reset: all outputs 0, state IDLE, hold buffer remaining mask 0. in_ready is 0 while rst is high.
- Latency: accepted slots appear on ex_* one cycle after the accepting edge. Each further DRAIN portion appears one cycle after the previous one.
- stall=1 (flush=0): all ex_* registers and the state/hold buffer are unchanged. No input is accepted.
- flush=1: at the next edge ex_valid=0 and ex_div_en=0, state goes to IDLE, and the remaining mask is cleared. Flush wins over stall and over a pending DRAIN. Inputs presented in the flush cycle are discarded.
- Group handshake: all-or-nothing per group. Upstream holds in_valid/payload stable until in_ready.
- in_valid all 0 in IDLE without stall: ex_valid goes to 0 at the next edge (bubble).
- Reset mid-DRAIN: the held remainder is discarded.

## Test plan
- LANES=2, in_valid=11, no special, pc 0x1000/0x1004, pc_pre 0x1004/0x1008 -> next cycle ex_valid=11, ex_age={0,1}, ex_br_pd=00, in_ready stays 1.
- LANES=2, slot0 special div, slot1 ALU -> lane1=slot0 (age 0, ex_div_en=1), lane0=slot1 (age 1). Slot1 pc_pre=0x2000 != pc+4 gives ex_br_pd[0]=1.
- LANES=2, both slots special -> cycle1: lane1=slot0, ex_valid=10, in_ready=0. Cycle2: lane1=slot1 (age 1). Cycle3: in_ready=1.
- LANES=4, specials at slots 1 and 3 -> cycle1 issues slots 0,1,2 (slot1 on lane3, slots 0,2 on lanes 0,1). Cycle2 issues slot3 on lane3 alone.
- stall held 3 cycles during DRAIN, then flush -> ex_* frozen during stall. After flush: ex_valid=0, state IDLE, in_ready=1 once flush and stall drop.
- rst asserted mid-DRAIN with in_valid=11 -> all outputs 0 the next cycle, in_ready=0 during rst, held remainder never issued.
